// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Purpose  : UART 8N1 receiver feeding an image loader that writes 32-bit
//            words to program RAM and releases the core on a valid checksum.
// Revision : 1.0
// ============================================================================
module uart_boot_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              err
);

   localparam int              TW          = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0]   C_BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]   C_HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [32:0]     C_MAX_WORDS = 33'd1 << ADDR_W;

   localparam logic [1:0] UART_IDLE  = 2'd0;
   localparam logic [1:0] UART_START = 2'd1;
   localparam logic [1:0] UART_DATA  = 2'd2;
   localparam logic [1:0] UART_STOP  = 2'd3;

   localparam logic [2:0] LD_HDR_LO = 3'd0;
   localparam logic [2:0] LD_HDR_HI = 3'd1;
   localparam logic [2:0] LD_DATA   = 3'd2;
   localparam logic [2:0] LD_CSUM   = 3'd3;
   localparam logic [2:0] LD_DONE   = 3'd4;
   localparam logic [2:0] LD_ERROR  = 3'd5;

   logic              r_rx_meta;
   logic              r_rx_sync;
   logic [1:0]        r_ustate;
   logic [TW-1:0]     r_timer;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_shift;

   logic [2:0]        r_lstate;
   logic [7:0]        r_n_lo;
   logic [15:0]       r_words_left;
   logic [1:0]        r_byte_idx;
   logic [7:0]        r_csum;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_we;

   logic              w_stop_sample;
   logic              w_byte_ok;
   logic              w_frame_err;
   logic [15:0]       w_hdr_n;

   assign w_stop_sample = (r_ustate == UART_STOP) && (r_timer == C_BIT_LAST);
   assign w_byte_ok     = w_stop_sample &&  r_rx_sync;
   assign w_frame_err   = w_stop_sample && !r_rx_sync;
   assign w_hdr_n       = {r_shift, r_n_lo};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_ustate  <= UART_IDLE;
         r_timer   <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
         case (r_ustate)
            UART_IDLE: begin
               if (!r_rx_sync) begin
                  r_ustate <= UART_START;
                  r_timer  <= '0;
               end
            end
            UART_START: begin
               if (r_timer == C_HALF_LAST) begin
                  r_timer   <= '0;
                  r_bit_cnt <= '0;
                  r_ustate  <= r_rx_sync ? UART_IDLE : UART_DATA;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            UART_DATA: begin
               if (r_timer == C_BIT_LAST) begin
                  r_timer   <= '0;
                  r_shift   <= {r_rx_sync, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == 3'd7) r_ustate <= UART_STOP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               if (r_timer == C_BIT_LAST) begin
                  r_timer  <= '0;
                  r_ustate <= UART_IDLE;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lstate     <= LD_HDR_LO;
         r_n_lo       <= '0;
         r_words_left <= '0;
         r_byte_idx   <= '0;
         r_csum       <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
      end else begin
         r_we <= 1'b0;
         if (r_we) r_addr <= r_addr + 1'b1;
         if (w_frame_err && r_lstate != LD_DONE && r_lstate != LD_ERROR) begin
            r_lstate <= LD_ERROR;
         end else if (w_byte_ok) begin
            case (r_lstate)
               LD_HDR_LO: begin
                  r_n_lo   <= r_shift;
                  r_lstate <= LD_HDR_HI;
               end
               LD_HDR_HI: begin
                  if ({17'd0, w_hdr_n} > C_MAX_WORDS) begin
                     r_lstate <= LD_ERROR;
                  end else if (w_hdr_n == 16'd0) begin
                     r_lstate <= LD_CSUM;
                  end else begin
                     r_lstate     <= LD_DATA;
                     r_words_left <= w_hdr_n;
                     r_byte_idx   <= '0;
                  end
               end
               LD_DATA: begin
                  r_csum                          <= r_csum ^ r_shift;
                  r_wdata[{r_byte_idx, 3'b000} +: 8] <= r_shift;
                  r_byte_idx                      <= r_byte_idx + 1'b1;
                  // The write fires next cycle even if the loader moves to CSUM now.
                  if (r_byte_idx == 2'd3) begin
                     r_we         <= 1'b1;
                     r_words_left <= r_words_left - 1'b1;
                     if (r_words_left == 16'd1) r_lstate <= LD_CSUM;
                  end
               end
               LD_CSUM: begin
                  r_lstate <= (r_shift == r_csum) ? LD_DONE : LD_ERROR;
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign core_hold = (r_lstate != LD_DONE);
   assign done      = (r_lstate == LD_DONE);
   assign err       = (r_lstate == LD_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Purpose  : Directed UART images against a byte-index model of the loader.
// Revision : 1.0
// ============================================================================
module tb_uart_boot_loader;

   localparam int CPB = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_hold;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   // Model: outcome derived from the position of each byte in the image.
   int          m_cnt;
   int          m_n;
   logic [7:0]  m_lo;
   logic [7:0]  m_csum;
   logic [31:0] m_word;
   bit          m_done;
   bit          m_err;
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          wr_seen;
   int          last_addr;
   logic [31:0] last_data;

   uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_hold (core_hold),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_n = 0; m_lo = 0; m_csum = 0; m_word = 0;
      m_done = 0; m_err = 0; wr_seen = 0;
      exp_addr.delete();
      exp_data.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      int k;
      if (m_done || m_err) return;
      if (m_cnt == 0) begin
         m_lo = b;
      end else if (m_cnt == 1) begin
         m_n = int'({b, m_lo});
         if (m_n > 256) m_err = 1;
      end else if (m_cnt < 2 + 4 * m_n) begin
         k = m_cnt - 2;
         m_csum = m_csum ^ b;
         m_word[8*(k%4) +: 8] = b;
         if (k % 4 == 3) begin
            exp_addr.push_back(k / 4);
            exp_data.push_back(m_word);
         end
      end else begin
         if (b == m_csum) m_done = 1; else m_err = 1;
      end
      m_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      if (stop_ok) model_byte(b);
      else if (!m_done && !m_err) m_err = 1;
      @(negedge clk) rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
   endtask

   task automatic end_check(input string tag);
      chk({tag, "_done"},      64'(done),      64'(m_done));
      chk({tag, "_err"},       64'(err),       64'(m_err));
      chk({tag, "_core_hold"}, 64'(core_hold), 64'(!m_done));
      chk({tag, "_pending"},   64'(exp_addr.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         total++;
         if (exp_addr.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write actual=addr %0d data %h required=no write", mem_addr, mem_wdata);
         end else begin
            int          ea;
            logic [31:0] ed;
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            if (int'(mem_addr) != ea || mem_wdata !== ed) begin
               bad++;
               $display("FAIL write actual=addr %0d data %h required=addr %0d data %h", mem_addr, mem_wdata, ea, ed);
            end
            wr_seen++;
            last_addr = int'(mem_addr);
            last_data = mem_wdata;
         end
      end
   end

   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_mem_we",    64'(mem_we),    64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_mem_addr",  64'(mem_addr),  64'd0);
      chk("rst_core_hold", 64'(core_hold), 64'd1);
      chk("rst_done",      64'(done),      64'd0);
      chk("rst_err",       64'(err),       64'd0);

      // Two-word image with good checksum.
      do_reset();
      send_byte(8'h02, 1); send_byte(8'h00, 1);
      send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
      send_byte(8'hEF, 1); send_byte(8'hBE, 1); send_byte(8'hAD, 1); send_byte(8'hDE, 1);
      chk("img2_model_csum", 64'(m_csum), 64'h2A);
      send_byte(8'h2A, 1);
      end_check("img2");
      chk("img2_writes",    64'(wr_seen),   64'd2);
      chk("img2_last_data", 64'(last_data), 64'hDEADBEEF);
      chk("img2_last_addr", 64'(last_addr), 64'd1);
      chk("img2_done_lit",  64'(done),      64'd1);
      send_byte(8'h55, 1);
      end_check("img2_ignore");

      // Empty image, good then bad checksum.
      do_reset();
      send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
      end_check("empty_ok");
      chk("empty_ok_writes", 64'(wr_seen), 64'd0);
      do_reset();
      send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h5A, 1);
      end_check("empty_bad");
      chk("empty_bad_err_lit", 64'(err), 64'd1);

      // One word, wrong checksum: write still happens.
      do_reset();
      send_byte(8'h01, 1); send_byte(8'h00, 1);
      send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
      send_byte(8'h00, 1);
      end_check("badcs");
      chk("badcs_data", 64'(last_data), 64'h44332211);
      chk("badcs_err_lit", 64'(err), 64'd1);

      // Oversized header, then data that must be ignored.
      do_reset();
      send_byte(8'h01, 1); send_byte(8'h01, 1);
      send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
      end_check("toolong");
      chk("toolong_writes", 64'(wr_seen), 64'd0);

      // Short glitch is not a start bit; a valid empty image then loads.
      do_reset();
      @(negedge clk) rx = 1'b0;
      repeat (CPB / 4) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_err", 64'(err), 64'd0);
      send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
      end_check("glitch");

      // Framing error in the header.
      do_reset();
      send_byte(8'h01, 1);
      send_byte(8'h00, 0);
      end_check("frame");
      chk("frame_err_lit", 64'(err), 64'd1);

      // Reset mid-image, then a fresh one-word image.
      do_reset();
      send_byte(8'h01, 1); send_byte(8'h00, 1); send_byte(8'h99, 1); send_byte(8'h88, 1);
      do_reset();
      send_byte(8'h01, 1); send_byte(8'h00, 1);
      send_byte(8'hA1, 1); send_byte(8'hB2, 1); send_byte(8'hC3, 1); send_byte(8'hD4, 1);
      send_byte(m_csum, 1);
      end_check("rstmid");
      chk("rstmid_writes", 64'(wr_seen),   64'd1);
      chk("rstmid_data",   64'(last_data), 64'hD4C3B2A1);
      chk("rstmid_addr",   64'(last_addr), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter ADDR_W, default 8, SHALL set the program-RAM word-address width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 Port rx  input  1  SHALL be the asynchronous UART serial line: 8N1, LSB first, idle high.
REQ-006 Port mem_we  output  1  SHALL be the program-RAM write strobe, one cycle per word.
REQ-007 Port mem_addr  output  ADDR_W  SHALL be the program-RAM word address.
REQ-008 Port mem_wdata  output  32  SHALL be the program-RAM write data.
REQ-009 Port core_hold  output  1  SHALL be high while the core must stay stalled at fetch.
REQ-010 Port done  output  1  SHALL be high once an image has loaded with a valid checksum.
REQ-011 Port err  output  1  SHALL be high after any framing, length or checksum error.

Function
REQ-012 rx SHALL pass through a 2-flop synchroniser; all UART logic SHALL use the synchronised value.
REQ-013 UART FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 In IDLE, a synchronised low SHALL move the FSM to START and clear the bit timer.
REQ-015 START SHALL resample at CLKS_PER_BIT/2 (integer division): low -> DATA, high -> IDLE (glitch, no byte).
REQ-016 DATA SHALL sample 8 bits, each CLKS_PER_BIT after the previous; the first sample is CLKS_PER_BIT after the start midpoint, LSB first.
REQ-017 STOP SHALL sample CLKS_PER_BIT after bit 7: high -> byte accepted that cycle; low -> framing error; either outcome returns to IDLE.
REQ-018 Loader FSM states SHALL be HDR_LO, HDR_HI, DATA, CSUM, DONE, ERROR; each accepted byte advances it at most one step.
REQ-019 HDR_LO/HDR_HI SHALL capture the 16-bit little-endian word count N.
REQ-020 If N > 2^ADDR_W, the loader SHALL enter ERROR on the HDR_HI byte; if N = 0, it SHALL go directly to CSUM.
REQ-021 DATA SHALL assemble each 4-byte group little-endian: first byte -> mem_wdata[7:0], fourth -> [31:24].
REQ-022 mem_we SHALL pulse high for exactly one cycle, the cycle after the fourth byte is accepted, with mem_wdata and mem_addr valid in that cycle.
REQ-023 mem_addr SHALL start at 0 and increment by 1 after each write; it SHALL NOT wrap, since N <= 2^ADDR_W.
REQ-024 After the Nth word is written, the loader SHALL move to CSUM.
REQ-025 The running checksum SHALL be the 8-bit XOR of all data bytes only (header and checksum bytes excluded).
REQ-026 In CSUM, a received byte equal to the running checksum SHALL move the loader to DONE; any other value SHALL move it to ERROR.
REQ-027 In DONE: core_hold = 0, done = 1, mem_we stays 0, and further bytes SHALL be ignored.
REQ-028 In ERROR: err = 1, core_hold = 1, mem_we stays 0, and further bytes SHALL be ignored; only rst exits ERROR.
REQ-029 A framing error in any state other than DONE or ERROR SHALL force ERROR the same cycle the stop bit is sampled.
REQ-030 mem_we SHALL be 0 whenever not in DATA; a write already scheduled SHALL still complete when the move to CSUM occurs in the same cycle.

Reset
REQ-031 rst SHALL force: UART FSM -> IDLE, loader -> HDR_LO, bit timer, bit counter, byte counter, checksum and mem_addr -> 0.
REQ-032 Reset values SHALL be mem_we = 0, mem_wdata = 0, core_hold = 1, done = 0, err = 0.
REQ-033 rst asserted mid-byte or mid-image SHALL discard partial data; the next start bit after rst deasserts begins a new header.
REQ-034 The synchroniser flops SHALL reset to 1 (idle).

Verification
REQ-035 Bytes 02 00 | 78 56 34 12 | EF BE AD DE | checksum (XOR of the 8 data bytes) -> writes 0x12345678 @0 and 0xDEADBEEF @1, then done = 1, core_hold = 0, err = 0.
REQ-036 Bytes 00 00 00 -> no mem_we, done = 1; with 00 00 5A instead -> err = 1, done = 0.
REQ-037 Header 01 00, data 11 22 33 44, checksum 00 (correct is 0x44) -> one write 0x44332211 @0, then err = 1, core_hold = 1.
REQ-038 With ADDR_W = 8, header 01 01 (N = 257) -> err = 1, no mem_we.
REQ-039 rx low pulse of CLKS_PER_BIT/4 cycles -> no byte accepted, loader stays in HDR_LO; a byte with low stop bit -> err = 1.
REQ-040 rst pulsed after 2 data bytes, then a full valid 1-word image -> single write @0 with the new data, done = 1.
